gate_tt_sequencer: RTL
======================

Name: gate_tt_sequencer

Overview:
- Controller that drives a 2-input combinational gate-under-test (e.g. an XNOR built from XOR+NOT) through every input combination and checks each response against a parameterised truth table.
- Sits beside the basic gate designs as the self-check sequencer.
- Owns the gate's A/B inputs, samples its Q output, and reports per-vector failures, an error count and pass/fail.

Parameters:
- TT, 4'b1001, expected truth table; expected Q for vector idx is TT[idx]. Default is XNOR.
- SETTLE_CYC, 2, cycles A/B are held before Q is sampled; legal range is ≥1.
- LOOPS, 1, number of full 4-vector passes per run; legal range is ≥1.
- CNT_W, 8, width of ErrCount.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  begin run; honoured only in IDLE or DONE.
- Abort  in  1  synchronous abort of a run in progress.
- Q  in  1  output of gate-under-test.
- A  out  1  gate input A, registered.
- B  out  1  gate input B, registered.
- Busy  out  1  high while a run is in progress (SETTLE or SAMPLE).
- Done  out  1  high in DONE; held until next Start, Abort or RST.
- Pass  out  1  valid when Done; equals 1 if no mismatch occurred in the run.
- FailMask  out  4  bit idx set if vector idx mismatched in any loop.
- ErrCount  out  CNT_W  total mismatches, saturating at all-ones.

Behaviour:
- Reset (RST=1, async): state=IDLE; A=B=Busy=Done=Pass=0; FailMask=0; ErrCount=0; idx=0; loop=0; settle counter=0.
- Reset mid-run aborts immediately with the same values.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Vector encoding: A=idx[1], B=idx[0]; idx runs 0,1,2,3 (A/B = 00,01,10,11).
- IDLE/DONE with Start=1 at an edge:
  - clear FailMask, ErrCount, Done, Pass;
  - idx=0, loop=0;
  - load A=B=0;
  - settle counter = SETTLE_CYC-1;
  - go to SETTLE.
- SETTLE: Busy=1, A/B stable. Decrement the counter each cycle. At the edge where counter==0, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- SAMPLE: Busy=1, one cycle. At the edge leaving SAMPLE, compare Q with TT[idx]. On mismatch:
  - set FailMask[idx];
  - ErrCount+=1, saturating (no wrap).
- Next-state decision at that same edge:
  - idx<3: idx+=1, load new A/B, reload settle counter, go to SETTLE.
  - idx==3 and loop<LOOPS-1: idx=0, loop+=1, A=B=0, reload counter, go to SETTLE.
  - idx==3 and loop==LOOPS-1: go to DONE. Pass set from the post-update ErrCount==0 (a mismatch on vector 3 counts). Done=1, Busy=0. A/B keep last vector (1,1).
- Per-vector cost is SETTLE_CYC+1 cycles. Done rises 4·LOOPS·(SETTLE_CYC+1) cycles after the Start edge (12 with defaults).
- Start while Busy=1: ignored.
- Start and Abort both high in IDLE/DONE: Abort wins; stays or returns to IDLE.
- Abort=1 while Busy at an edge:
  - go to IDLE, Busy=0, Done=0, Pass=0, A=B=0;
  - FailMask/ErrCount keep partial values until next Start.
- Abort in DONE: go to IDLE, Done=0, Pass=0, counters kept.
- Q is sampled only in SAMPLE. Q glitches during SETTLE have no effect.
- No combinational path from Q or Start to any output; all outputs are registered.

Test Plan:
- Good XNOR (Q = A~^B), defaults, Start pulse -> A/B sequence 00,01,10,11, each held 3 cycles; Done=1 exactly 12 cycles after Start edge; Pass=1, FailMask=0000, ErrCount=0.
- Q tied 0, defaults -> Done after 12 cycles; Pass=0, FailMask=1001, ErrCount=2.
- XOR gate (Q = A^B) attached, LOOPS=3, SETTLE_CYC=1 -> Done after 24 cycles; FailMask=1111, ErrCount=12, Pass=0; Start pulses during Busy produce no restart.
- Saturation: CNT_W=2, LOOPS=2, Q = A^B -> ErrCount=3 (not wrapped to 0), Pass=0; a new Start from DONE clears ErrCount to 0 at the Start edge.
- Abort during vector 2 SETTLE with Q tied 0 (vector 0 already failed) -> next edge IDLE, Busy=0, Done=0, A=B=0, FailMask=0001, ErrCount=1; a subsequent Start runs a full clean sequence.
- RST asserted asynchronously mid-SAMPLE (between edges) -> all outputs 0 immediately without a clock edge; after RST release the block idles until Start.

Source files
------------

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: walks a 2-input gate through all four input vectors,
// checks each response against truth table TT and reports mismatches.
module gate_tt_sequencer #(
    parameter logic [3:0] TT         = 4'b1001,
    parameter int         SETTLE_CYC = 2,
    parameter int         LOOPS      = 1,
    parameter int         CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Q,
    output logic             A,
    output logic             B,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [3:0]       FailMask,
    output logic [CNT_W-1:0] ErrCount
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [LW-1:0] loop, loop_n;
    logic [SW-1:0] cnt, cnt_n;
    logic a_n, b_n, done_n, pass_n;
    logic [3:0] fail_n;
    logic [CNT_W-1:0] err_n;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            loop     <= '0;
            cnt      <= '0;
            A        <= 1'b0;
            B        <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
            FailMask <= '0;
            ErrCount <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            loop     <= loop_n;
            cnt      <= cnt_n;
            A        <= a_n;
            B        <= b_n;
            Busy     <= state_n == SETTLE || state_n == SAMPLE;
            Done     <= done_n;
            Pass     <= pass_n;
            FailMask <= fail_n;
            ErrCount <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        loop_n  = loop;
        cnt_n   = cnt;
        a_n     = A;
        b_n     = B;
        done_n  = Done;
        pass_n  = Pass;
        fail_n  = FailMask;
        err_n   = ErrCount;
        // Abort has priority everywhere; partial results are kept for inspection
        if (Abort) begin
            state_n = IDLE;
            done_n  = 1'b0;
            pass_n  = 1'b0;
            a_n     = 1'b0;
            b_n     = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (Start) begin
                    state_n = SETTLE;
                    idx_n   = '0;
                    loop_n  = '0;
                    cnt_n   = SW'(SETTLE_CYC - 1);
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    fail_n  = '0;
                    err_n   = '0;
                end
                SETTLE: if (cnt == '0) state_n = SAMPLE; else cnt_n = cnt - 1'b1;
                SAMPLE: begin
                    if (Q != TT[idx]) begin
                        fail_n[idx] = 1'b1;
                        err_n       = &ErrCount ? ErrCount : ErrCount + 1'b1;
                    end
                    if (idx != 2'd3 || loop != LW'(LOOPS - 1)) begin
                        state_n      = SETTLE;
                        idx_n        = idx + 2'd1;
                        loop_n       = idx == 2'd3 ? loop + 1'b1 : loop;
                        cnt_n        = SW'(SETTLE_CYC - 1);
                        {a_n, b_n}   = idx + 2'd1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        pass_n  = err_n == '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
